// File: rtl/background_drawer_if.sv
// background_drawer_if: start/done control, lookup coordinate/colour and VGA pixel-write signals of the background drawer.
//   master (drawer): in  start, bg_colour; out x_cord, y_cord, vga_x, vga_y, vga_colour, plot, busy, done
//   slave  (environment): the same signals with the opposite directions
interface background_drawer_if;
  logic       start;
  logic [2:0] bg_colour;
  logic [8:0] x_cord;
  logic [8:0] y_cord;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;
  modport master (input start, bg_colour, output x_cord, y_cord, vga_x, vga_y, vga_colour, plot, busy, done);
  modport slave (output start, bg_colour, input x_cord, y_cord, vga_x, vga_y, vga_colour, plot, busy, done);
endinterface

// File: rtl/background_drawer.sv
// background_drawer: sweeps every H_RES x V_RES coordinate into the background lookup and emits one VGA pixel write per cycle.
//   clock, reset (async, active-high)
//   bus.master: start, bg_colour in; x_cord/y_cord to lookup; vga_x/vga_y/vga_colour/plot to VGA; busy/done to control FSM
//   BG_DRAWER_SKIP_BLACK_EN: when defined, black pixels are not plotted
module background_drawer #(
  parameter int H_RES = 320,
  parameter int V_RES = 240
) (
  input logic clock,
  input logic reset,
  background_drawer_if.master bus
);
  typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, DONE} state_t;
  localparam logic [8:0] X_LAST = 9'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);
  state_t state, state_n;
  logic [8:0] x_n, y_n;
  logic       valid;
  logic [2:0] colour_hold;
  logic       x_wrap, y_last;
  assign x_wrap = bus.x_cord == X_LAST;
  assign y_last = bus.y_cord == Y_LAST;
  always_comb begin
    state_n = state;
    x_n = bus.x_cord;
    y_n = bus.y_cord;
    case (state)
      IDLE: state_n = bus.start ? SWEEP : IDLE;
      SWEEP: begin
        x_n = x_wrap ? 9'd0 : bus.x_cord + 9'd1;
        y_n = x_wrap ? (y_last ? 9'd0 : bus.y_cord + 9'd1) : bus.y_cord;
        state_n = x_wrap && y_last ? FLUSH : SWEEP;
      end
      FLUSH: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // The lookup's own output register is the colour stage: bg_colour arrives in the same
  // cycle as the delayed coordinates, and colour_hold keeps the last colour between writes.
  assign bus.vga_colour = valid ? bus.bg_colour : colour_hold;
`ifdef BG_DRAWER_SKIP_BLACK_EN
  assign bus.plot = valid && bus.bg_colour != 3'b000;
`else
  assign bus.plot = valid;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      bus.x_cord <= '0;
      bus.y_cord <= '0;
      bus.vga_x <= '0;
      bus.vga_y <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      valid <= 1'b0;
      colour_hold <= '0;
    end else begin
      state <= state_n;
      bus.x_cord <= x_n;
      bus.y_cord <= y_n;
      bus.busy <= state_n == SWEEP || state_n == FLUSH;
      bus.done <= state_n == DONE;
      valid <= state == SWEEP;
      colour_hold <= bus.vga_colour;
      if (state == SWEEP) begin
        bus.vga_x <= bus.x_cord;
        bus.vga_y <= bus.y_cord[7:0];
      end
    end
  end
endmodule

// File: doc/background_drawer.md
# background_drawer

Full-frame scan sequencer for the static background layer. On a start pulse it sweeps every on-screen coordinate (320x240) into the background colour lookup stage and receives that stage's registered 3-bit colour one cycle later. It realigns each colour with its coordinate and emits one VGA-adapter pixel write per cycle. It sits between the game control FSM (start/done) and the VGA adapter, with the background lookup hanging off its coordinate port.

## Interface
- H_RES, 320, horizontal pixel count; x sweeps 0..H_RES-1
- V_RES, 240, vertical pixel count; y sweeps 0..V_RES-1
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  request one frame sweep; sampled only in IDLE
- bg_colour  in  3  colour from background lookup, valid 1 cycle after x_cord/y_cord
- x_cord  out  9  x coordinate driven to background lookup
- y_cord  out  9  y coordinate driven to background lookup (upper bit always 0)
- vga_x  out  9  pixel x to VGA adapter
- vga_y  out  8  pixel y to VGA adapter
- vga_colour  out  3  pixel colour to VGA adapter
- plot  out  1  write strobe to VGA adapter; vga_x/vga_y/vga_colour valid when high
- busy  out  1  high while a sweep is in progress (SWEEP or FLUSH)
- done  out  1  one-cycle pulse when the final pixel has been written

## Operation
- States: IDLE, SWEEP, FLUSH, DONE; all outputs registered.
- Reset values: state IDLE; x_cord=0, y_cord=0, vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, done=0.
- IDLE:
  - x_cord/y_cord held at 0.
  - start=1 -> SWEEP.
- SWEEP:
  - Each cycle, x_cord increments by 1.
  - At x_cord=H_RES-1: x_cord wraps to 0 and y_cord increments.
  - At (H_RES-1, V_RES-1): -> FLUSH, coords return to 0.
- Pipeline register:
  - Captures the current coordinate pair plus a valid bit each cycle.
  - On the next cycle, vga_x/vga_y take the captured coordinates, vga_colour takes bg_colour, and plot takes valid.
  - vga_x/vga_y/vga_colour hold their last value when plot=0.
- FLUSH: one cycle; the last pixel's plot is issued; -> DONE.
- DONE:
  - done=1 for exactly one cycle, plot=0.
  - -> IDLE.
  - start asserted in the DONE cycle is ignored.
- start while busy: ignored, with no restart and no queuing.
- Arithmetic: counters are 9-bit unsigned compared against parameters. vga_y is the low 8 bits of the delayed y. No coordinate ever equals H_RES or V_RES.
- Reset mid-sweep: immediate return to IDLE with reset values. No done pulse. The pixel in flight is dropped.

## Timing
- Start accepted at edge E0: x_cord=0, y_cord=0, busy=1 after E0.
- Lookup-to-plot latency: 1 cycle. Pixel presented after edge En is plotted after En+1 with plot=1.
- First write (0,0) after E1.
- Last coordinate (319,239) presented after E76799 and plotted after E76800 (FLUSH).
- done=1 after E76801 only; busy=0 from E76801.
- Earliest accepted restart: start high in the IDLE cycle after E76802.
- Throughput: one pixel per clock; 76800 writes per frame, contiguous with no gaps.

## Configuration
- BG_DRAWER_SKIP_BLACK_EN:
  - Defined: plot is gated low whenever bg_colour=3'b000, so only non-black pixels are written. vga_x/vga_y/vga_colour still update, and sweep length and done timing are unchanged.
  - Undefined: every pixel is written, including black (default; required for full-frame erase).

## Test plan
- Reset, then a 1-cycle start pulse: after E1, plot=1 with vga_x=0, vga_y=0. Exactly 76800 plot pulses with strictly raster-ordered coordinates. done pulses once after E76801; busy falls at the same edge.
- bg_colour model = registered function of (x_cord, y_cord), e.g. white on y=0 and green on y>=236: every plotted vga_colour matches the model value for the same vga_x/vga_y (alignment check). Include the row wrap at x=319->0.
- start held high for 200k cycles: exactly two complete sweeps, each of 76800 writes, separated by at least one IDLE cycle. start during SWEEP/FLUSH/DONE causes no restart.
- Reset asserted asynchronously mid-sweep at pixel (100,50): all outputs go to reset values without a clock edge, no done. A later start writes a full frame from (0,0).
- With BG_DRAWER_SKIP_BLACK_EN defined and bg_colour=3'b000 except white on x=0: plot count = 240, and the done cycle is identical to the undefined build.
- H_RES=4, V_RES=3: 12 writes in raster order and done after E13.
